spi_master_byte: RTL and testbench
==================================

// Module: spi_master_byte
// PURPOSE
//   SPI mode-3 master (CPOL=1, CPHA=1), MSB first, with a byte-wide handshake.
//   Partner of the SPI slave byte interface: drives SCLK/SS/MOSI, samples MISO.
//   Used on the FPGA that initiates transfers. Also used as the bench driver for the slave.
// PARAMETERS
//   CLK_DIV   4  SCLK half-period in sysClk cycles; legal range >=2; SCLK = sysClk/(2*CLK_DIV)
//   SS_GUARD  2  sysClk cycles between SS fall and 1st SCLK fall, and between last SCLK rise and SS rise; >=1
//   GAP       4  min sysClk cycles SS stays high between frames; >=1
// PORTS
//   sysClk    in   1  system clock; one clock; reset is asynchronous and active-low
//   usrReset  in   1  asynchronous, active-low reset
//   txStart   in   1  request a byte transfer; accepted only when txReady=1
//   tx        in   8  byte to send; captured in the cycle txStart is accepted
//   txReady   out  1  1 = idle, can accept txStart
//   rxValid   out  1  1-cycle pulse: rx holds the byte just received
//   rx        out  8  received byte; stable until the next rxValid
//   busy      out  1  1 whenever SS is asserted or GAP is running
//   SCLK      out  1  SPI clock; idles high
//   MOSI      out  1  master out; changes on SCLK falling edge
//   MISO      in   1  master in; sampled on SCLK rising edge; double-flop synchronised
//   SS        out  1  slave select, active low
// BEHAVIOUR
//   Reset values: SCLK=1, SS=1, MOSI=1, txReady=1, rxValid=0, rx=8'h00, busy=0, state=IDLE.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE:  txReady=1. On txStart: latch tx into shift reg, drive SS=0, go to SETUP.
//          txReady drops in the next cycle.
//   SETUP: hold for SS_GUARD cycles, then go to SHIFT.
//   SHIFT: half-period counter 0..CLK_DIV-1.
//          SCLK falls: MOSI <= shreg[7].
//          SCLK rises, CLK_DIV cycles later: shift synchronised MISO into the LSB.
//          8 falls and 8 rises per byte; SHIFT lasts 16*CLK_DIV cycles; SCLK ends high.
//   HOLD:  SS_GUARD cycles. On entry: rx <= shreg, rxValid=1 for exactly one cycle.
//          Then SS=1 and go to GAP.
//   GAP:   GAP cycles with SS=1, busy=1. Then IDLE, txReady=1, MOSI=1.
//   MISO sync adds 2 sysClk of delay. CLK_DIV>=2 keeps the sample inside the bit window.
//   txStart while txReady=0: ignored; no queueing; tx not sampled.
//   tx changing mid-frame: no effect (value was latched at accept).
//   Reset asserted mid-frame: all outputs return to reset values immediately (async).
//   No rxValid for an aborted byte; rx is cleared to 0.
//   Bit counter is 3 bits and wraps 7->0 only at the HOLD transition; no partial bytes are emitted.
// CONFIGURATION
//   SPI_MASTER_BURST_EN defined:
//     In HOLD, if txStart=1 in its 1st cycle: latch tx, keep SS=0, and go straight to SHIFT.
//     No SETUP, no GAP in this case.
//     txReady=1 for the whole HOLD state in burst mode; rxValid for the previous byte still pulses.
//   SPI_MASTER_BURST_EN undefined:
//     SS deasserts after every byte; txStart in HOLD is ignored; txReady=1 only in IDLE.
// TESTING
//   1. Loopback (MISO=MOSI), CLK_DIV=4, send 8'hA5:
//      rxValid pulses once, rx=8'hA5, SS low for 2*SS_GUARD+64 sysClk.
//   2. Mode-3 slave model returns 8'h55, master sends 8'hAA:
//      slave sees 8'hAA, master rx=8'h55, exactly 8 SCLK rising edges.
//   3. txStart held high through a frame (8'h3C) with tx changed to 8'hFF mid-frame:
//      MOSI carries 8'h3C; one frame only, then GAP>=4 cycles.
//   4. usrReset low after the 4th SCLK rise:
//      SCLK=SS=MOSI=1 the same cycle, no rxValid, rx=0, txReady=1 after release.
//   5. BURST_EN, txStart in HOLD with 8'h01 then 8'h02:
//      SS stays low across both, 2 rxValid pulses, 16 SCLK rises.
//   6. No BURST_EN, same stimulus:
//      SS rises between bytes, each SS-high period >= GAP cycles.

Source files
------------

// File: rtl/spi_master_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_master_byte                                               |
// | Purpose  : SPI mode-3 master (CPOL=1, CPHA=1), MSB first, one byte per   |
// |            handshake. Drives SCLK/SS/MOSI, samples a double-flop         |
// |            synchronised MISO on each SCLK rising edge.                   |
// | Params   : CLK_DIV  - SCLK half-period in sysClk cycles (>=2)            |
// |            SS_GUARD - cycles between SS fall and 1st SCLK fall, and the  |
// |                       HOLD length before SS rises (>=1)                  |
// |            GAP      - minimum SS-high cycles between frames (>=1)        |
// | Ports    : sysClk, usrReset (async, active low)                          |
// |            txStart/tx/txReady  - byte request handshake                  |
// |            rxValid/rx          - received byte, 1-cycle valid pulse      |
// |            busy                - SS asserted or inter-frame gap running  |
// |            SCLK/MOSI/MISO/SS   - SPI pins (SS active low)                |
// | Config   : SPI_MASTER_BURST_EN - when defined, a txStart in the first    |
// |            HOLD cycle chains the next byte without releasing SS.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_master_byte #(
  parameter int CLK_DIV  = 4,
  parameter int SS_GUARD = 2,
  parameter int GAP      = 4
) (
  input  logic       sysClk,
  input  logic       usrReset,
  input  logic       txStart,
  input  logic [7:0] tx,
  output logic       txReady,
  output logic       rxValid,
  output logic [7:0] rx,
  output logic       busy,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // One shared counter serves the guard, half-period and gap timers.
  localparam int MAX_A   = (CLK_DIV > SS_GUARD) ? CLK_DIV : SS_GUARD;
  localparam int MAX_CNT = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [2:0]         bit_q,      bit_d;
  logic [7:0]         shreg_q,    shreg_d;
  logic               sclk_q,     sclk_d;
  logic               mosi_q,     mosi_d;
  logic               ss_q,       ss_d;
  logic               tx_ready_q, tx_ready_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_q,       rx_d;
  logic               busy_q,     busy_d;
  logic               miso_s1_q,  miso_s1_d;
  logic               miso_s2_q,  miso_s2_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    rx_d       = rx_q;
    busy_d     = busy_q;
    miso_s1_d  = MISO;
    miso_s2_d  = miso_s1_q;

    case (state_q)
      ST_IDLE: begin
        if (txStart) begin
          shreg_d    = tx;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == CNT_W'(SS_GUARD - 1)) begin
          // First SCLK fall coincides with entering SHIFT.
          cnt_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = shreg_q[7];
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture the synchronised MISO bit.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[6:0], miso_s2_q};
          end else if (bit_q == 3'd7) begin
            // Eighth high half-period done: byte complete, SCLK stays high.
            bit_d      = 3'd0;
            rx_d       = shreg_q;
            rx_valid_d = 1'b1;
            tx_ready_d = BURST;
            state_d    = ST_HOLD;
          end else begin
            bit_d  = bit_q + 3'd1;
            sclk_d = 1'b0;
            mosi_d = shreg_q[7];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (BURST && (cnt_q == '0) && txStart) begin
          // Chain the next byte: SS stays low, no setup guard or gap.
          shreg_d    = tx;
          cnt_d      = '0;
          sclk_d     = 1'b0;
          mosi_d     = tx[7];
          tx_ready_d = 1'b0;
          state_d    = ST_SHIFT;
        end else if (cnt_q == CNT_W'(SS_GUARD - 1)) begin
          cnt_d      = '0;
          ss_d       = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d      = '0;
          tx_ready_d = 1'b1;
          mosi_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        bit_d      = 3'd0;
        sclk_d     = 1'b1;
        mosi_d     = 1'b1;
        ss_d       = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysClk or negedge usrReset) begin
    if (!usrReset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h00;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b1;
      ss_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_q       <= 8'h00;
      busy_q     <= 1'b0;
      miso_s1_q  <= 1'b1;
      miso_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_q       <= rx_d;
      busy_q     <= busy_d;
      miso_s1_q  <= miso_s1_d;
      miso_s2_q  <= miso_s2_d;
    end
  end

  assign txReady = tx_ready_q;
  assign rxValid = rx_valid_q;
  assign rx      = rx_q;
  assign busy    = busy_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_master_byte                                            |
// | Purpose  : Self-checking bench for spi_master_byte: loopback and mode-3  |
// |            slave model, expected rx bytes queued at stimulus time and    |
// |            popped on rxValid. Burst expectations follow                  |
// |            SPI_MASTER_BURST_EN.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spi_master_byte;
  localparam int CLK_DIV  = 4;
  localparam int SS_GUARD = 2;
  localparam int GAP      = 4;

  logic       sysClk   = 1'b0;
  logic       usrReset = 1'b0;
  logic       txStart  = 1'b0;
  logic [7:0] tx       = '0;
  logic       txReady, rxValid, busy, SCLK, MOSI, SS, MISO;
  logic [7:0] rx;

  logic       loopback = 1'b1;
  logic       miso_sl  = 1'b1;
  assign MISO = loopback ? MOSI : miso_sl;

  always #5 sysClk = ~sysClk;

  spi_master_byte #(
    .CLK_DIV (CLK_DIV),
    .SS_GUARD(SS_GUARD),
    .GAP     (GAP)
  ) dut (
    .sysClk  (sysClk),
    .usrReset(usrReset),
    .txStart (txStart),
    .tx      (tx),
    .txReady (txReady),
    .rxValid (rxValid),
    .rx      (rx),
    .busy    (busy),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .SS      (SS)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode-3 slave: drive on SCLK fall, sample on SCLK rise.
  logic [7:0] sl_sh = '0;
  logic [7:0] sl_tx = '0;
  always @(negedge SS)   sl_sh = sl_tx;
  always @(negedge SCLK) if (!SS) miso_sl = sl_sh[7];
  always @(posedge SCLK) if (!SS) sl_sh = {sl_sh[6:0], MOSI};

  // Monitor and scoreboard, sampled on the inactive clock edge.
  logic [7:0] exp_q[$];
  int rises = 0, rxv = 0, ss_falls = 0, ss_rises = 0;
  int ss_low_run = 0, last_ss_low = 0, ss_high_run = 0, last_ss_high = 0, gap_run = 0;
  logic [7:0] mosi_cap  = '0;
  logic       prev_sclk = 1'b1;
  logic       prev_ss   = 1'b1;

  always @(negedge sysClk) begin
    if (usrReset) begin
      if (SCLK && !prev_sclk) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], MOSI};
      end
      if (!SS && prev_ss) begin
        ss_falls++;
        last_ss_high = ss_high_run;
        ss_low_run   = 0;
        gap_run      = 0;
      end
      if (SS && !prev_ss) begin
        ss_rises++;
        last_ss_low = ss_low_run;
        ss_high_run = 0;
      end
      if (!SS) ss_low_run++;
      else     ss_high_run++;
      if (SS && busy) gap_run++;
      if (rxValid) begin
        rxv++;
        if (exp_q.size() == 0) check_eq("rx_unexpected", 32'(exp_q.size()), 32'd1);
        else                   check_eq("rx_data", 32'(rx), 32'(exp_q.pop_front()));
      end
    end
    prev_sclk = SCLK;
    prev_ss   = SS;
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [7:0] e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (txReady) begin ok = 1'b1; break; end
      @(negedge sysClk);
    end
    check_eq("ready_timeout", 32'(ok), 32'd1);
    txStart = 1'b1;
    tx      = b;
    if (push) exp_q.push_back(e);
    @(negedge sysClk);
    txStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sysClk);
      if (txReady && !busy) begin ok = 1'b1; break; end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rises >= target) begin ok = 1'b1; break; end
      @(negedge sysClk);
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int  r0, v0, f0, s0;
    bit  ok;

    // Reset state
    repeat (3) @(negedge sysClk);
    check_eq("rst_sclk",    32'(SCLK),    32'd1);
    check_eq("rst_ss",      32'(SS),      32'd1);
    check_eq("rst_mosi",    32'(MOSI),    32'd1);
    check_eq("rst_txready", 32'(txReady), 32'd1);
    check_eq("rst_rxvalid", 32'(rxValid), 32'd0);
    check_eq("rst_rx",      32'(rx),      32'h00);
    check_eq("rst_busy",    32'(busy),    32'd0);
    usrReset = 1'b1;
    repeat (2) @(negedge sysClk);

    // 1: loopback 0xA5
    r0 = rises; v0 = rxv;
    send_byte(8'hA5, 1'b1, 8'hA5);
    wait_idle("t1_done");
    check_eq("t1_rises",   32'(rises - r0), 32'd8);
    check_eq("t1_rxvalid", 32'(rxv - v0),   32'd1);
    check_eq("t1_ss_low",  32'(last_ss_low), 32'(2 * SS_GUARD + 16 * CLK_DIV));
    check_eq("t1_mosi",    32'(mosi_cap),   32'hA5);
    check_eq("t1_gap",     32'(gap_run),    32'(GAP));

    // 2: slave returns 0x55, master sends 0xAA
    loopback = 1'b0; sl_tx = 8'h55;
    r0 = rises;
    send_byte(8'hAA, 1'b1, 8'h55);
    wait_idle("t2_done");
    check_eq("t2_slave_rx", 32'(sl_sh),      32'hAA);
    check_eq("t2_rises",    32'(rises - r0), 32'd8);
    check_eq("t2_mosi",     32'(mosi_cap),   32'hAA);
    loopback = 1'b1;

    // 3: txStart held high, tx changed mid-frame
    r0 = rises; v0 = rxv; f0 = ss_falls;
    send_byte(8'h3C, 1'b1, 8'h3C);
    txStart = 1'b1;
    wait_rises(r0 + 4, "t3_rise4_timeout");
    tx = 8'hFF;
    wait_rises(r0 + 8, "t3_rise8_timeout");
    txStart = 1'b0;
    wait_idle("t3_done");
    repeat (20) @(negedge sysClk);
    check_eq("t3_frames",  32'(ss_falls - f0), 32'd1);
    check_eq("t3_mosi",    32'(mosi_cap),      32'h3C);
    check_eq("t3_rxvalid", 32'(rxv - v0),      32'd1);
    check_eq("t3_gap",     32'(gap_run),       32'(GAP));

    // 4: reset after 4th SCLK rise
    r0 = rises; v0 = rxv;
    send_byte(8'h00, 1'b0, 8'h00);
    wait_rises(r0 + 4, "t4_rise4_timeout");
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!SCLK) begin ok = 1'b1; break; end
      @(negedge sysClk);
    end
    check_eq("t4_sclk_low_timeout", 32'(ok), 32'd1);
    usrReset = 1'b0;
    #1;
    check_eq("t4_sclk",    32'(SCLK),    32'd1);
    check_eq("t4_ss",      32'(SS),      32'd1);
    check_eq("t4_mosi",    32'(MOSI),    32'd1);
    check_eq("t4_rx",      32'(rx),      32'h00);
    check_eq("t4_rxvalid", 32'(rxValid), 32'd0);
    repeat (3) @(negedge sysClk);
    usrReset = 1'b1;
    repeat (30) @(negedge sysClk);
    check_eq("t4_no_rxvalid", 32'(rxv - v0), 32'd0);
    check_eq("t4_txready",    32'(txReady),  32'd1);
    check_eq("t4_busy",       32'(busy),     32'd0);

    // 5/6: 0x01 then txStart with 0x02 in the first HOLD cycle
    r0 = rises; v0 = rxv; f0 = ss_falls; s0 = ss_rises;
    send_byte(8'h01, 1'b1, 8'h01);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysClk);
      if (rxValid) begin ok = 1'b1; break; end
    end
    check_eq("t5_rxvalid_timeout", 32'(ok), 32'd1);
    txStart = 1'b1;
    tx      = 8'h02;
`ifdef SPI_MASTER_BURST_EN
    check_eq("t5_ready_in_hold", 32'(txReady), 32'd1);
    exp_q.push_back(8'h02);
`else
    check_eq("t6_ready_in_hold", 32'(txReady), 32'd0);
`endif
    @(negedge sysClk);
    txStart = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    wait_idle("t5_done");
    check_eq("t5_ss_rises", 32'(ss_rises - s0), 32'd1);
    check_eq("t5_frames",   32'(ss_falls - f0), 32'd1);
    check_eq("t5_rises",    32'(rises - r0),    32'd16);
    check_eq("t5_rxvalid",  32'(rxv - v0),      32'd2);
    check_eq("t5_mosi",     32'(mosi_cap),      32'h02);
`else
    wait_idle("t6_first_done");
    check_eq("t6_hold_ignored", 32'(ss_falls - f0), 32'd1);
    send_byte(8'h02, 1'b1, 8'h02);
    wait_idle("t6_done");
    check_eq("t6_gap_ok",   32'(last_ss_high >= GAP), 32'd1);
    check_eq("t6_ss_rises", 32'(ss_rises - s0), 32'd2);
    check_eq("t6_frames",   32'(ss_falls - f0), 32'd2);
    check_eq("t6_rises",    32'(rises - r0),    32'd16);
    check_eq("t6_rxvalid",  32'(rxv - v0),      32'd2);
    check_eq("t6_mosi",     32'(mosi_cap),      32'h02);
`endif
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
